// File: rtl/hud_pkg.sv
// Shared HUD definitions: RGB444 pixel type, default colour palette and the
// state encoding of the bar scaler.
package hud_pkg;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t HUD_BLACK       = 12'h000;
  localparam rgb444_t HUD_FILL_COLOR  = 12'h0F0;
  localparam rgb444_t HUD_GHOST_COLOR = 12'hF80;
  localparam rgb444_t HUD_BASE_COLOR  = 12'h333;
  localparam rgb444_t HUD_FLASH_COLOR = 12'hFFF;

  typedef enum logic {
    SCALER_IDLE,
    SCALER_RUN
  } scaler_state_t;

endpackage

// File: rtl/bar_scaler.sv
// Restoring divider used to scale health into bar pixels.
// One quotient bit is produced per RUN cycle, so a division takes DIVIDEND_W
// cycles. A start pulse in any state (re)loads the operands, which lets the
// caller restart with fresh data without waiting for the current division.
//
// Ports:
//   clk_in    pixel clock
//   rst_in    synchronous active-high reset, aborts any division
//   start     load dividend and begin a division
//   dividend  numerator, sampled on start
//   divisor   denominator, must be held stable during RUN
//   quotient  result, valid while done is high
//   done      high for the final RUN cycle (suppressed when restarting)
//   busy      high while a division is in progress
module bar_scaler
  import hud_pkg::*;
#(
  parameter int DIVIDEND_W = 19,
  parameter int DIVISOR_W  = 8,
  parameter int QUOTIENT_W = 11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOTIENT_W-1:0] quotient,
  output logic                  done,
  output logic                  busy
);

  localparam int              CNT_W     = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  scaler_state_t         state, state_nx;
  logic [CNT_W-1:0]      step;
  logic                  last;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [DIVIDEND_W-1:0] work, work_nx;
  logic [DIVISOR_W-1:0]  rem, rem_nx;
  logic [DIVISOR_W:0]    partial;
  logic [DIVISOR_W-1:0]  diff;
  logic                  q_bit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= SCALER_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every combinational output is assigned a default first so no path
  // leaves it unassigned and a latch can never be inferred.
  always_comb begin
    state_nx = state;
    case (state)
      SCALER_IDLE: if (start) state_nx = SCALER_RUN;
      SCALER_RUN:  if (!start && last) state_nx = SCALER_IDLE;
      default:     state_nx = SCALER_IDLE;
    endcase
  end

  // One restoring step: the remainder is always below the divisor, so the
  // trial value fits in DIVISOR_W+1 bits and the difference in DIVISOR_W.
  always_comb begin
    partial = {rem, work[DIVIDEND_W-1]};
    q_bit   = partial >= {1'b0, divisor};
    diff    = DIVISOR_W'(partial - {1'b0, divisor});
    rem_nx  = q_bit ? diff : partial[DIVISOR_W-1:0];
    work_nx = {work[DIVIDEND_W-2:0], q_bit};
  end

  assign last     = (step == LAST_STEP);
  assign busy     = (state == SCALER_RUN);
  assign done     = busy && last && !start;
  assign quotient = work_nx[QUOTIENT_W-1:0];

  // NOTE: the datapath has no reset; it is always loaded by start before its
  // contents are used, and done is gated by the reset FSM.
  always_ff @(posedge clk_in) begin
    if (start) begin
      work <= dividend;
      rem  <= '0;
      step <= '0;
    end else if (busy) begin
      work <= work_nx;
      rem  <= rem_nx;
      step <= step + 1'b1;
    end
  end

endmodule

// File: rtl/animated_health_bar.sv
// On-screen health bar with a draining "ghost" segment and a damage flash.
// Health is netted from damage/heal strobes each cycle, scaled to a pixel
// length by bar_scaler, and the ghost segment trails the fill down at one
// pixel every DRAIN_PERIOD frames.
//
// Ports:
//   clk_in, rst_in         pixel clock, synchronous active-high reset
//   valid_in               active-video qualifier
//   hcount_in, vcount_in   current pixel column / line
//   new_frame_in           one-cycle frame strobe (drives drain and flash)
//   dmg_valid_in/amt_in    damage event
//   heal_valid_in/amt_in   heal event
//   pixel_out              registered RGB444 pixel, 1-cycle latency
//   hp_out, dead_out       registered health and hp==0 flag
//   busy_out               ghost still draining or scaler running
module animated_health_bar
  import hud_pkg::*;
#(
  parameter int      POS_X        = 480,
  parameter int      POS_Y        = 720,
  parameter int      WIDTH        = 96,
  parameter int      HEIGHT       = 32,
  parameter int      MAX_HP       = 100,
  parameter int      HP_W         = 8,
  parameter rgb444_t FILL_COLOR   = HUD_FILL_COLOR,
  parameter rgb444_t GHOST_COLOR  = HUD_GHOST_COLOR,
  parameter rgb444_t BASE_COLOR   = HUD_BASE_COLOR,
  parameter rgb444_t FLASH_COLOR  = HUD_FLASH_COLOR,
  parameter int      DRAIN_PERIOD = 2,
  parameter int      FLASH_FRAMES = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            valid_in,
  input  logic [10:0]     hcount_in,
  input  logic [9:0]      vcount_in,
  input  logic            new_frame_in,
  input  logic            dmg_valid_in,
  input  logic [HP_W-1:0] dmg_amt_in,
  input  logic            heal_valid_in,
  input  logic [HP_W-1:0] heal_amt_in,
  output rgb444_t         pixel_out,
  output logic [HP_W-1:0] hp_out,
  output logic            dead_out,
  output logic            busy_out
);

  localparam int DIV_W   = HP_W + 11;
  localparam int SUM_W   = HP_W + 2;
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
  localparam int DRAIN_W = $clog2(DRAIN_PERIOD + 1);

  localparam logic signed [SUM_W-1:0] MAX_HP_S  = SUM_W'(MAX_HP);
  localparam logic [HP_W-1:0]         MAX_HP_V  = HP_W'(MAX_HP);
  localparam logic [10:0]             WIDTH_PX  = 11'(WIDTH);
  localparam logic [10:0]             X_START   = 11'(POS_X);
  localparam logic [10:0]             X_END     = 11'(POS_X + WIDTH);
  localparam logic [9:0]              Y_START   = 10'(POS_Y);
  localparam logic [9:0]              Y_END     = 10'(POS_Y + HEIGHT);
  localparam logic [FLASH_W-1:0]      FLASH_MAX = FLASH_W'(FLASH_FRAMES);
  localparam logic [DRAIN_W-1:0]      DRAIN_TOP = DRAIN_W'(DRAIN_PERIOD - 1);

  logic [HP_W-1:0]         hp, hp_nx;
  logic signed [SUM_W-1:0] hp_sum;
  logic [10:0]             fill_px, fill_nx, ghost_px;
  logic [FLASH_W-1:0]      flash_cnt;
  logic [DRAIN_W-1:0]      drain_cnt;

  logic                    scaler_start, scaler_done, scaler_busy;
  logic [DIV_W-1:0]        scaler_dividend;
  logic [10:0]             scaler_quotient;

  logic [10:0]             dx;
  logic                    in_bar;
  rgb444_t                 pixel_nx;

  // Damage and heal are netted at full signed width before clamping, so a
  // large hit paired with a large heal never saturates halfway.
  always_comb begin
    hp_sum = $signed({2'b00, hp});
    if (dmg_valid_in)  hp_sum = hp_sum - $signed({2'b00, dmg_amt_in});
    if (heal_valid_in) hp_sum = hp_sum + $signed({2'b00, heal_amt_in});
    if (hp_sum[SUM_W-1])       hp_nx = '0;
    else if (hp_sum > MAX_HP_S) hp_nx = MAX_HP_V;
    else                        hp_nx = hp_sum[HP_W-1:0];
  end

  assign scaler_start    = (hp_nx != hp) && !rst_in;
  assign scaler_dividend = DIV_W'(hp_nx) * DIV_W'(WIDTH);

  bar_scaler #(
    .DIVIDEND_W (DIV_W),
    .DIVISOR_W  (HP_W),
    .QUOTIENT_W (11)
  ) u_scaler (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (scaler_start),
    .dividend (scaler_dividend),
    .divisor  (MAX_HP_V),
    .quotient (scaler_quotient),
    .done     (scaler_done),
    .busy     (scaler_busy)
  );

  assign fill_nx = scaler_done ? scaler_quotient : fill_px;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hp        <= MAX_HP_V;
      dead_out  <= 1'b0;
      fill_px   <= WIDTH_PX;
      ghost_px  <= WIDTH_PX;
      drain_cnt <= '0;
      flash_cnt <= '0;
    end else begin
      hp       <= hp_nx;
      dead_out <= (hp_nx == '0);
      fill_px  <= fill_nx;

      // Ghost is compared against the fill value being written this cycle so
      // a drain step can never dip below a freshly written fill.
      if (fill_nx > ghost_px) begin
        ghost_px  <= fill_nx;
        drain_cnt <= '0;
      end else if (fill_nx == ghost_px) begin
        drain_cnt <= '0;
      end else if (new_frame_in) begin
        if (drain_cnt == DRAIN_TOP) begin
          ghost_px  <= ghost_px - 1'b1;
          drain_cnt <= '0;
        end else begin
          drain_cnt <= drain_cnt + 1'b1;
        end
      end

      // Only an actual loss of health flashes; netted heals do not.
      if (dmg_valid_in && (hp_nx < hp))
        flash_cnt <= FLASH_MAX;
      else if (new_frame_in && (flash_cnt != '0))
        flash_cnt <= flash_cnt - 1'b1;
    end
  end

  assign hp_out   = hp;
  assign busy_out = (ghost_px != fill_px) || scaler_busy;

  assign dx     = hcount_in - X_START;
  assign in_bar = (hcount_in >= X_START) && (hcount_in < X_END) &&
                  (vcount_in >= Y_START) && (vcount_in < Y_END);

  always_comb begin
    pixel_nx = HUD_BLACK;
    if (valid_in && in_bar) begin
      if (dx < fill_px)       pixel_nx = (flash_cnt != '0) ? FLASH_COLOR : FILL_COLOR;
      else if (dx < ghost_px) pixel_nx = GHOST_COLOR;
      else                    pixel_nx = BASE_COLOR;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) pixel_out <= HUD_BLACK;
    else        pixel_out <= pixel_nx;
  end

endmodule

// File: tb/tb_animated_health_bar.sv
// Self-checking bench for animated_health_bar with default parameters.
module tb_animated_health_bar;

  localparam int POS_X = 480;
  localparam int POS_Y = 720;

  localparam logic [11:0] C_NONE  = 12'h000;
  localparam logic [11:0] C_FILL  = 12'h0F0;
  localparam logic [11:0] C_GHOST = 12'hF80;
  localparam logic [11:0] C_BASE  = 12'h333;
  localparam logic [11:0] C_FLASH = 12'hFFF;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        new_frame_in;
  logic        dmg_valid_in;
  logic [7:0]  dmg_amt_in;
  logic        heal_valid_in;
  logic [7:0]  heal_amt_in;
  logic [11:0] pixel_out;
  logic [7:0]  hp_out;
  logic        dead_out;
  logic        busy_out;

  always #5 clk_in = ~clk_in;

  animated_health_bar dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (valid_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .new_frame_in  (new_frame_in),
    .dmg_valid_in  (dmg_valid_in),
    .dmg_amt_in    (dmg_amt_in),
    .heal_valid_in (heal_valid_in),
    .heal_amt_in   (heal_amt_in),
    .pixel_out     (pixel_out),
    .hp_out        (hp_out),
    .dead_out      (dead_out),
    .busy_out      (busy_out)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [11:0] exp;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  typedef struct {
    string       name;
    int          hc;
    int          vc;
    logic        valid;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a pixel coordinate, queue its expected colour, clock once and
  // compare the registered pixel against the oldest queued expectation.
  task automatic probe(input string name, input int hc, input int vc,
                       input logic v, input logic [11:0] exp);
    sb_entry_t e;
    hcount_in = 11'(hc);
    vcount_in = 10'(vc);
    valid_in  = v;
    sb_q.push_back('{name, exp});
    @(posedge clk_in);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(e.name, 32'(pixel_out), 32'(e.exp));
    end
  endtask

  task automatic bar(input string name, input int dx, input logic [11:0] exp);
    probe(name, POS_X + dx, POS_Y, 1'b1, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      new_frame_in = 1'b1;
      @(posedge clk_in);
      #1;
      new_frame_in = 1'b0;
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic set_event(input logic dv, input int da, input logic hv, input int ha);
    dmg_valid_in  = dv;
    dmg_amt_in    = 8'(da);
    heal_valid_in = hv;
    heal_amt_in   = 8'(ha);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"origin",     POS_X,      POS_Y,      1'b1, C_FILL};
    vecs[1] = '{"left_out",   POS_X - 1,  POS_Y,      1'b1, C_NONE};
    vecs[2] = '{"right_in",   POS_X + 95, POS_Y,      1'b1, C_FILL};
    vecs[3] = '{"right_out",  POS_X + 96, POS_Y,      1'b1, C_NONE};
    vecs[4] = '{"top_out",    POS_X + 10, POS_Y - 1,  1'b1, C_NONE};
    vecs[5] = '{"bottom_in",  POS_X + 10, POS_Y + 31, 1'b1, C_FILL};
    vecs[6] = '{"bottom_out", POS_X + 10, POS_Y + 32, 1'b1, C_NONE};
    vecs[7] = '{"no_valid",   POS_X + 10, POS_Y + 5,  1'b0, C_NONE};
    vecs[8] = '{"mid",        POS_X + 48, POS_Y + 16, 1'b1, C_FILL};
    vecs[9] = '{"far_out",    10,         10,         1'b1, C_NONE};

    rst_in       = 1'b1;
    valid_in     = 1'b1;
    hcount_in    = 11'(POS_X);
    vcount_in    = 10'(POS_Y);
    new_frame_in = 1'b0;
    set_event(1'b1, 50, 1'b0, 0);  // must be discarded during reset
    wait_cycles(2);
    check("rst_pixel", 32'(pixel_out), 0);
    check("rst_hp", 32'(hp_out), 100);
    check("rst_dead", 32'(dead_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    set_event(1'b0, 0, 1'b0, 0);
    rst_in = 1'b0;

    // Full bar geometry after reset.
    for (int i = 0; i < 10; i++)
      probe(vecs[i].name, vecs[i].hc, vecs[i].vc, vecs[i].valid, vecs[i].exp);
    check("post_rst_hp", 32'(hp_out), 100);

    // Damage 25: hp 75, fill 96 -> 72 on the 19th cycle after the update.
    set_event(1'b1, 25, 1'b0, 0);
    bar("dmg_pre", 72, C_FILL);
    set_event(1'b0, 0, 1'b0, 0);
    check("dmg_hp", 32'(hp_out), 75);
    check("dmg_dead", 32'(dead_out), 0);
    for (int i = 0; i < 19; i++) bar("dmg_hold", 72, C_FLASH);
    bar("dmg_fill_written", 72, C_GHOST);
    bar("dmg_ghost80", 80, C_GHOST);
    bar("dmg_flash71", 71, C_FLASH);
    check("dmg_busy", 32'(busy_out), 1);
    frames(47);
    check("drain_busy47", 32'(busy_out), 1);
    frames(1);
    check("drain_busy48", 32'(busy_out), 0);
    bar("drain_base72", 72, C_BASE);
    bar("drain_fill71", 71, C_FILL);

    // Overkill: hp 75 - 150 clamps to 0.
    set_event(1'b1, 150, 1'b0, 0);
    bar("ovk_pre", 0, C_FILL);
    set_event(1'b0, 0, 1'b0, 0);
    check("ovk_hp", 32'(hp_out), 0);
    check("ovk_dead", 32'(dead_out), 1);
    wait_cycles(20);
    bar("ovk_dx0", 0, C_GHOST);
    bar("ovk_dx71", 71, C_GHOST);
    bar("ovk_dx72", 72, C_BASE);

    // Heal to 50, fill 48; flash still live from the overkill.
    set_event(1'b0, 0, 1'b1, 50);
    bar("heal50_pre", 0, C_GHOST);
    set_event(1'b0, 0, 1'b0, 0);
    check("heal50_hp", 32'(hp_out), 50);
    check("heal50_dead", 32'(dead_out), 0);
    wait_cycles(20);
    bar("heal50_flash47", 47, C_FLASH);
    bar("heal50_ghost48", 48, C_GHOST);
    frames(60);
    bar("heal50_fill47", 47, C_FILL);
    bar("heal50_base48", 48, C_BASE);
    check("heal50_busy", 32'(busy_out), 0);

    // Simultaneous dmg 10 + heal 30: net +20, no flash, ghost snaps to 67.
    set_event(1'b1, 10, 1'b1, 30);
    bar("sim_pre", 66, C_BASE);
    set_event(1'b0, 0, 1'b0, 0);
    check("sim_hp", 32'(hp_out), 70);
    wait_cycles(20);
    bar("sim_fill66", 66, C_FILL);
    bar("sim_base67", 67, C_BASE);
    check("sim_busy", 32'(busy_out), 0);

    // Heal to 90, then heal 50 saturates at 100.
    set_event(1'b0, 0, 1'b1, 20);
    bar("heal90_pre", 66, C_FILL);
    set_event(1'b0, 0, 1'b0, 0);
    check("heal90_hp", 32'(hp_out), 90);
    wait_cycles(20);
    set_event(1'b0, 0, 1'b1, 50);
    bar("sat_pre", 95, C_BASE);
    set_event(1'b0, 0, 1'b0, 0);
    check("sat_hp", 32'(hp_out), 100);
    wait_cycles(20);
    bar("sat_fill95", 95, C_FILL);
    bar("sat_edge96", 96, C_NONE);
    check("sat_busy", 32'(busy_out), 0);

    // Restart: second hit 5 cycles after the first; only fill 76 appears.
    set_event(1'b1, 10, 1'b0, 0);
    bar("rs_first", 86, C_FILL);
    set_event(1'b0, 0, 1'b0, 0);
    check("rs_hp90", 32'(hp_out), 90);
    for (int i = 0; i < 4; i++) bar("rs_gap", 86, C_FLASH);
    set_event(1'b1, 10, 1'b0, 0);
    bar("rs_second", 86, C_FLASH);
    set_event(1'b0, 0, 1'b0, 0);
    check("rs_hp80", 32'(hp_out), 80);
    for (int i = 0; i < 19; i++) bar("rs_no_intermediate", 86, C_FLASH);
    bar("rs_final86", 86, C_GHOST);
    bar("rs_flash75", 75, C_FLASH);
    bar("rs_ghost76", 76, C_GHOST);
    check("rs_busy", 32'(busy_out), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
